// File: rtl/pipeline_mem.sv
// Memory (M) pipeline stage: one M register, data-memory request generation,
// load formatting and a RUN/WAIT handshake FSM with a bus-error timeout.
module pipeline_mem #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluResultE_i,
  input  logic [31:0] writeDataE_i,
  input  logic [31:0] extendedImmE_i,
  input  logic [31:0] pcPlus4E_i,
  input  logic        regWriteEnE_i,
  input  logic [4:0]  rdIdxE_i,
  input  logic [1:0]  resultSrcE_i,
  input  logic        memReadEnE_i,
  input  logic        memWriteEnE_i,
  input  logic [2:0]  funct3E_i,
  input  logic        flushM_i,
  output logic [31:0] dmemAddr_o,
  output logic        dmemRe_o,
  output logic        dmemWe_o,
  output logic [3:0]  dmemBe_o,
  output logic [31:0] dmemWdata_o,
  input  logic [31:0] dmemRdata_i,
  input  logic        dmemReady_i,
  output logic [31:0] aluResultM_o,
  output logic [31:0] extendedImmM_o,
  output logic [31:0] pcPlus4M_o,
  output logic [31:0] memReadDataM_o,
  output logic        regWriteEnM_o,
  output logic [4:0]  rdIdxM_o,
  output logic [1:0]  resultSrcM_o,
  output logic        stallReqM_o,
  output logic        misalignM_o,
  output logic        busErrM_o
);

  // Handshake: a request (dmemRe_o/dmemWe_o) is held with stable address,
  // enables and data until the cycle dmemReady_i=1 is seen, which completes it.
  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [31:0] alu_q, alu_d, wdata_q, wdata_d, imm_q, imm_d, pc4_q, pc4_d;
  logic        reg_we_q, reg_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  src_q, src_d;
  logic [2:0]  f3_q, f3_d;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_mem, misalign, mem_op, timeout, stall, req;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem   = mem_re_q | mem_we_q;
  assign misalign = is_mem & (((f3_q[1:0] == 2'b01) & alu_q[0]) |
                              ((f3_q[1:0] == 2'b10) & (alu_q[1:0] != 2'b00)));
  assign mem_op   = is_mem & ~misalign;
  assign timeout  = (state_q == ST_WAIT) & (cnt_q == MAX_WAIT_C) & ~dmemReady_i;
  assign stall    = mem_op & ~dmemReady_i & ~timeout;
  assign req      = mem_op & ~timeout;

  // M register next state: hold on stall, bubble on flush, else capture EX.
  always_comb begin
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    imm_d    = imm_q;
    pc4_d    = pc4_q;
    reg_we_d = reg_we_q;
    rd_d     = rd_q;
    src_d    = src_q;
    mem_re_d = mem_re_q;
    mem_we_d = mem_we_q;
    f3_d     = f3_q;
    if (!stall) begin
      if (flushM_i) begin
        alu_d    = '0;
        wdata_d  = '0;
        imm_d    = '0;
        pc4_d    = '0;
        reg_we_d = 1'b0;
        rd_d     = '0;
        src_d    = '0;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        f3_d     = '0;
      end else begin
        alu_d    = aluResultE_i;
        wdata_d  = writeDataE_i;
        imm_d    = extendedImmE_i;
        pc4_d    = pcPlus4E_i;
        reg_we_d = regWriteEnE_i;
        rd_d     = rdIdxE_i;
        src_d    = resultSrcE_i;
        mem_re_d = memReadEnE_i;
        mem_we_d = memWriteEnE_i;
        f3_d     = funct3E_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_op && !dmemReady_i) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (dmemReady_i || timeout) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q    <= '0;
      wdata_q  <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      reg_we_q <= 1'b0;
      rd_q     <= '0;
      src_q    <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      f3_q     <= '0;
      state_q  <= ST_RUN;
      cnt_q    <= '0;
    end else begin
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      imm_q    <= imm_d;
      pc4_q    <= pc4_d;
      reg_we_q <= reg_we_d;
      rd_q     <= rd_d;
      src_q    <= src_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      f3_q     <= f3_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dmemAddr_o = {alu_q[31:2], 2'b00};
  assign dmemRe_o   = mem_re_q & req;
  assign dmemWe_o   = mem_we_q & req;

  always_comb begin
    dmemBe_o = 4'b0000;
    if (dmemWe_o) begin
      case (f3_q[1:0])
        2'b00:   dmemBe_o = 4'b0001 << alu_q[1:0];
        2'b01:   dmemBe_o = alu_q[1] ? 4'b1100 : 4'b0011;
        default: dmemBe_o = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   dmemWdata_o = {4{wdata_q[7:0]}};
      2'b01:   dmemWdata_o = {2{wdata_q[15:0]}};
      default: dmemWdata_o = wdata_q;
    endcase
  end

  assign ld_byte = dmemRdata_i[8*alu_q[1:0] +: 8];
  assign ld_half = alu_q[1] ? dmemRdata_i[31:16] : dmemRdata_i[15:0];

  always_comb begin
    memReadDataM_o = '0;
    if (mem_re_q) begin
      case (f3_q)
        3'b000:  memReadDataM_o = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  memReadDataM_o = {{16{ld_half[15]}}, ld_half};
        3'b100:  memReadDataM_o = {24'd0, ld_byte};
        3'b101:  memReadDataM_o = {16'd0, ld_half};
        default: memReadDataM_o = dmemRdata_i;
      endcase
    end
  end

  assign aluResultM_o   = alu_q;
  assign extendedImmM_o = imm_q;
  assign pcPlus4M_o     = pc4_q;
  assign rdIdxM_o       = rd_q;
  assign resultSrcM_o   = src_q;
  assign regWriteEnM_o  = reg_we_q & ~stall & ~misalign & ~timeout;
  assign stallReqM_o    = stall;
  assign misalignM_o    = misalign;
  assign busErrM_o      = timeout;

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: directed scenarios plus randomized instruction
// streams checked against an instruction-level reference model.
module tb_pipeline_mem;

  localparam int MW = 4;

  typedef struct {
    logic [31:0] alu, wd, imm, pc4;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic        mr, mw;
    logic [2:0]  f3;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluResultE_i, writeDataE_i, extendedImmE_i, pcPlus4E_i;
  logic        regWriteEnE_i, memReadEnE_i, memWriteEnE_i, flushM_i;
  logic [4:0]  rdIdxE_i;
  logic [1:0]  resultSrcE_i;
  logic [2:0]  funct3E_i;
  logic [31:0] dmemAddr_o, dmemWdata_o, dmemRdata_i;
  logic        dmemRe_o, dmemWe_o, dmemReady_i;
  logic [3:0]  dmemBe_o;
  logic [31:0] aluResultM_o, extendedImmM_o, pcPlus4M_o, memReadDataM_o;
  logic        regWriteEnM_o, stallReqM_o, misalignM_o, busErrM_o;
  logic [4:0]  rdIdxM_o;
  logic [1:0]  resultSrcM_o;

  int checks = 0;
  int failures = 0;

  // values observed during the most recent run_instr call
  logic [31:0] obs_ld, obs_wd;
  logic [3:0]  obs_be;
  logic        obs_mis;
  int          obs_stall, obs_bus;

  pipeline_mem #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .aluResultE_i(aluResultE_i), .writeDataE_i(writeDataE_i),
    .extendedImmE_i(extendedImmE_i), .pcPlus4E_i(pcPlus4E_i),
    .regWriteEnE_i(regWriteEnE_i), .rdIdxE_i(rdIdxE_i),
    .resultSrcE_i(resultSrcE_i), .memReadEnE_i(memReadEnE_i),
    .memWriteEnE_i(memWriteEnE_i), .funct3E_i(funct3E_i),
    .flushM_i(flushM_i),
    .dmemAddr_o(dmemAddr_o), .dmemRe_o(dmemRe_o), .dmemWe_o(dmemWe_o),
    .dmemBe_o(dmemBe_o), .dmemWdata_o(dmemWdata_o),
    .dmemRdata_i(dmemRdata_i), .dmemReady_i(dmemReady_i),
    .aluResultM_o(aluResultM_o), .extendedImmM_o(extendedImmM_o),
    .pcPlus4M_o(pcPlus4M_o), .memReadDataM_o(memReadDataM_o),
    .regWriteEnM_o(regWriteEnM_o), .rdIdxM_o(rdIdxM_o),
    .resultSrcM_o(resultSrcM_o), .stallReqM_o(stallReqM_o),
    .misalignM_o(misalignM_o), .busErrM_o(busErrM_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic exp_misalign(input instr_t i);
    int size;
    if (!(i.mr || i.mw)) return 1'b0;
    size = (i.f3[1:0] == 2'b00) ? 1 : (i.f3[1:0] == 2'b01) ? 2 : 4;
    return (int'(i.alu[1:0]) % size) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input instr_t i);
    int lane = int'(i.alu[1:0]);
    if (i.f3[1:0] == 2'b00) return 4'(1 << lane);
    if (i.f3[1:0] == 2'b01) return 4'(3 << (2 * (lane / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input instr_t i);
    if (i.f3[1:0] == 2'b00) return (i.wd & 32'hFF) * 32'h0101_0101;
    if (i.f3[1:0] == 2'b01) return (i.wd & 32'hFFFF) * 32'h0001_0001;
    return i.wd;
  endfunction

  function automatic logic [31:0] exp_load(input instr_t i, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(i.alu[1:0]))) & 32'hFF;
    h = (rd >> (16 * (int'(i.alu[1:0]) / 2))) & 32'hFFFF;
    case (i.f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_e(input instr_t i);
    aluResultE_i   = i.alu;
    writeDataE_i   = i.wd;
    extendedImmE_i = i.imm;
    pcPlus4E_i     = i.pc4;
    regWriteEnE_i  = i.we;
    rdIdxE_i       = i.rd;
    resultSrcE_i   = i.rs;
    memReadEnE_i   = i.mr;
    memWriteEnE_i  = i.mw;
    funct3E_i      = i.f3;
  endtask

  function automatic instr_t rand_filler();
    instr_t f;
    f.alu = $urandom; f.wd = $urandom; f.imm = $urandom; f.pc4 = $urandom;
    f.we = 1'($urandom_range(0, 1)); f.rd = 5'($urandom); f.rs = 2'($urandom);
    f.mr = 1'b0; f.mw = 1'b0; f.f3 = 3'($urandom);
    return f;
  endfunction

  function automatic instr_t rand_mem();
    instr_t m;
    int     sel;
    m = rand_filler();
    if ($urandom_range(0, 1) == 1) begin
      m.mr = 1'b1;
      sel  = $urandom_range(0, 4);
      m.f3 = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 :
             (sel == 3) ? 3'b100 : 3'b101;
    end else begin
      m.mw = 1'b1;
      m.f3 = 3'($urandom_range(0, 2));
    end
    return m;
  endfunction

  function automatic instr_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] wd);
    instr_t m;
    m = rand_filler();
    m.mr = mr; m.mw = mw; m.f3 = f3; m.alu = alu; m.wd = wd; m.we = mr;
    return m;
  endfunction

  // Sends one instruction through M with memory latency lat (ready in M
  // cycle lat, counting from 0), then checks the held EX filler follows.
  task automatic run_instr(input instr_t i, input int lat, input logic [31:0] rdata,
                           input bit flush_stall);
    instr_t      filler;
    logic        mis, memop, done, tout, req;
    int          last;
    logic [9:0]  exp_ctl, obs_ctl;
    drive_e(i);
    flushM_i = 1'b0; dmemReady_i = 1'b0;
    @(posedge clk); #1;
    filler = rand_filler();
    drive_e(filler);
    mis   = exp_misalign(i);
    memop = (i.mr || i.mw) && !mis;
    last  = !memop ? 0 : (lat <= MW ? lat : MW);
    obs_stall = 0; obs_bus = 0; obs_mis = 1'b0;
    obs_ld = '0; obs_wd = '0; obs_be = '0;
    for (int c = 0; c <= last; c++) begin
      dmemReady_i = memop && (c == lat);
      dmemRdata_i = (c == lat) ? rdata : $urandom;
      flushM_i    = flush_stall && (c < last);
      #4;
      done = (c == last);
      tout = memop && done && (lat > MW);
      req  = memop && !tout;
      exp_ctl = {req && i.mr, req && i.mw, (req && i.mw) ? exp_be(i) : 4'h0,
                 memop && !done, mis, tout, done && i.we && !mis && !tout};
      obs_ctl = {dmemRe_o, dmemWe_o, dmemBe_o, stallReqM_o, misalignM_o,
                 busErrM_o, regWriteEnM_o};
      checks++;
      if (obs_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl cyc=%0d got re,we,be,stall,mis,berr,rwe=%b want %b", c, obs_ctl, exp_ctl);
      end
      if (stallReqM_o) obs_stall++;
      if (busErrM_o) obs_bus++;
      if (misalignM_o) obs_mis = 1'b1;
      if (c == 0) begin
        obs_be = dmemBe_o; obs_wd = dmemWdata_o;
        checks++;
        if ({aluResultM_o, extendedImmM_o, pcPlus4M_o, rdIdxM_o, resultSrcM_o, dmemAddr_o} !==
            {i.alu, i.imm, i.pc4, i.rd, i.rs, i.alu[31:2], 2'b00}) begin
          failures++;
          $display("FAIL passthru got alu=%h imm=%h pc4=%h rd=%0d src=%0d addr=%h want %h %h %h %0d %0d",
                   aluResultM_o, extendedImmM_o, pcPlus4M_o, rdIdxM_o, resultSrcM_o, dmemAddr_o,
                   i.alu, i.imm, i.pc4, i.rd, i.rs);
        end
      end
      if (req && i.mw) begin
        checks++;
        if (dmemWdata_o !== exp_wd(i) || dmemAddr_o !== {i.alu[31:2], 2'b00}) begin
          failures++;
          $display("FAIL store_data cyc=%0d got %h want %h", c, dmemWdata_o, exp_wd(i));
        end
      end
      if (done && !tout && memop && i.mr) begin
        obs_ld = memReadDataM_o;
        checks++;
        if (memReadDataM_o !== exp_load(i, rdata)) begin
          failures++;
          $display("FAIL load_data got %h want %h", memReadDataM_o, exp_load(i, rdata));
        end
      end else if (!i.mr) begin
        checks++;
        if (memReadDataM_o !== 32'd0) begin
          failures++;
          $display("FAIL load_zero got %h want 0", memReadDataM_o);
        end
      end
      @(posedge clk); #1;
    end
    dmemReady_i = 1'b0; flushM_i = 1'b0;
    #4;
    checks++;
    if ({aluResultM_o, extendedImmM_o, pcPlus4M_o, rdIdxM_o, resultSrcM_o, regWriteEnM_o,
         dmemRe_o, dmemWe_o, stallReqM_o} !==
        {filler.alu, filler.imm, filler.pc4, filler.rd, filler.rs, filler.we, 3'b000}) begin
      failures++;
      $display("FAIL held_ex got alu=%h rwe=%b re=%b we=%b stall=%b want alu=%h rwe=%b",
               aluResultM_o, regWriteEnM_o, dmemRe_o, dmemWe_o, stallReqM_o, filler.alu, filler.we);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; flushM_i = 1'b0; dmemReady_i = 1'b0; dmemRdata_i = $urandom;
    drive_e(mk(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0));
    repeat (2) @(posedge clk);
    #4;
    checks++;
    if ({dmemAddr_o, dmemRe_o, dmemWe_o, dmemBe_o, aluResultM_o, pcPlus4M_o, regWriteEnM_o,
         stallReqM_o, busErrM_o, memReadDataM_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got addr=%h re=%b we=%b alu=%h rwe=%b stall=%b want all 0",
               dmemAddr_o, dmemRe_o, dmemWe_o, aluResultM_o, regWriteEnM_o, stallReqM_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(mk(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0), 0, 32'h80FF_FF7F, 1'b0);
    checks++;
    if (obs_ld !== 32'hFFFF_FF80 || obs_stall !== 0) begin
      failures++;
      $display("FAIL lb_signext got data=%h stalls=%0d want ffffff80 0", obs_ld, obs_stall);
    end
    run_instr(mk(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF), 0, 32'h0, 1'b0);
    checks++;
    if (obs_be !== 4'b1100 || obs_wd !== 32'hBEEF_BEEF) begin
      failures++;
      $display("FAIL sh_lanes got be=%b wd=%h want 1100 beefbeef", obs_be, obs_wd);
    end
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0), 0, 32'h0, 1'b0);
    checks++;
    if (obs_mis !== 1'b1 || obs_stall !== 0) begin
      failures++;
      $display("FAIL lw_misalign got mis=%b stalls=%0d want 1 0", obs_mis, obs_stall);
    end
    run_instr(mk(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0), 3, 32'h9ABC_0000, 1'b0);
    checks++;
    if (obs_ld !== 32'h0000_9ABC || obs_stall !== 3) begin
      failures++;
      $display("FAIL lhu_wait got data=%h stalls=%0d want 00009abc 3", obs_ld, obs_stall);
    end
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0), 1000, 32'h0, 1'b0);
    checks++;
    if (obs_bus !== 1 || obs_stall !== MW) begin
      failures++;
      $display("FAIL timeout got berr_pulses=%0d stalls=%0d want 1 %0d", obs_bus, obs_stall, MW);
    end
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0), MW, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_flush();
    for (int n = 0; n < 4; n++) begin
      drive_e(rand_mem());
      flushM_i = 1'b1; dmemReady_i = 1'b0;
      @(posedge clk); #1;
      flushM_i = 1'b0;
      drive_e(rand_filler());
      #4;
      checks++;
      if ({dmemRe_o, dmemWe_o, dmemBe_o, regWriteEnM_o, stallReqM_o, aluResultM_o, rdIdxM_o} !== '0) begin
        failures++;
        $display("FAIL flush_bubble got re=%b we=%b rwe=%b stall=%b alu=%h want all 0",
                 dmemRe_o, dmemWe_o, regWriteEnM_o, stallReqM_o, aluResultM_o);
      end
    end
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_7008, 32'h0), 2, 32'hCAFE_F00D, 1'b1);
    run_instr(mk(1'b0, 1'b1, 3'b000, 32'h0000_7009, 32'h0000_00A5), 3, 32'h0, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    drive_e(mk(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0));
    dmemReady_i = 1'b0;
    @(posedge clk); #1;
    drive_e(rand_filler());
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #4;
    checks++;
    if (stallReqM_o !== 1'b1 || dmemRe_o !== 1'b1) begin
      failures++;
      $display("FAIL wait2_active got stall=%b re=%b want 1 1", stallReqM_o, dmemRe_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    checks++;
    if ({dmemAddr_o, dmemRe_o, dmemWe_o, dmemBe_o, dmemWdata_o, aluResultM_o, extendedImmM_o,
         pcPlus4M_o, memReadDataM_o, regWriteEnM_o, rdIdxM_o, resultSrcM_o, stallReqM_o,
         misalignM_o, busErrM_o} !== '0) begin
      failures++;
      $display("FAIL reset_in_wait got re=%b stall=%b alu=%h rwe=%b berr=%b want all 0",
               dmemRe_o, stallReqM_o, aluResultM_o, regWriteEnM_o, busErrM_o);
    end
    run_instr(mk(1'b1, 1'b0, 3'b010, 32'h0000_9000, 32'h0), 0, 32'h0BAD_BEEF, 1'b0);
  endtask

  task automatic test_random();
    instr_t i;
    for (int n = 0; n < 80; n++) begin
      i = ($urandom_range(0, 9) < 3) ? rand_filler() : rand_mem();
      run_instr(i, $urandom_range(0, MW + 2), $urandom, ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++)
      run_instr(rand_mem(), 0, $urandom, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
